bcd_add_ctrl: RTL

- Sequencing controller for the team's 2-digit BCD operand-entry and adder datapath.
- Owns the operand digit counters, which are key-driven and modulo 10.
- Snapshots both operands on a start request and runs a single shared one-digit BCD adder serially, least significant digit first.
- Publishes a registered (DIGITS+1)-digit BCD sum with busy/done status; sits between the KEY inputs and the seven-segment decoders.

---
 rtl/bcd_add_ctrl_if.sv | 23 ++
 rtl/bcd_add_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_add_ctrl_if.sv
// Bus between the KEY front end, the BCD add controller and the seven-segment decoders.
interface bcd_add_ctrl_if #(
  parameter int DIGITS = 2
);
  logic [DIGITS-1:0]       inc_a;
  logic [DIGITS-1:0]       inc_b;
  logic                    start;
  logic [4*DIGITS-1:0]     a_bcd;
  logic [4*DIGITS-1:0]     b_bcd;
  logic [4*(DIGITS+1)-1:0] sum_bcd;
  logic                    busy;
  logic                    done;

  modport master (
    output inc_a, inc_b, start,
    input  a_bcd, b_bcd, sum_bcd, busy, done
  );

  modport slave (
    input  inc_a, inc_b, start,
    output a_bcd, b_bcd, sum_bcd, busy, done
  );
endinterface

// File: rtl/bcd_add_ctrl.sv
// Key-driven BCD operand counters plus a serial one-digit BCD adder, LSD first.
// Define BCD_ADD_AUTO_EN to re-run the add automatically after any operand edit.
module bcd_add_ctrl #(
  parameter int DIGITS = 2
) (
  input  logic          clk,
  input  logic          reset,
  bcd_add_ctrl_if.slave bus
);
  localparam int NIN = 2*DIGITS + 1;
  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW  = 4*(DIGITS+1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ADD, S_DONE} state_t;

  logic [NIN-1:0] in_raw;
  logic [NIN-1:0] samp_q, samp_d;
  logic [NIN-1:0] prev_q, prev_d;
  logic [NIN-1:0] mask_q, mask_d;
  logic [NIN-1:0] pulse;

  logic [4*DIGITS-1:0] a_vec, b_vec;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [4*DIGITS-1:0] wa_q, wa_d;
  logic [4*DIGITS-1:0] wb_q, wb_d;
  logic [4*DIGITS-1:0] wsum_q, wsum_d;
  logic [SW-1:0]       sum_q, sum_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                start_pulse;
  logic                launch;
  logic [4:0]          tmp;
  logic [4:0]          tmp_adj;
  logic [3:0]          dig;
  logic                carry_n;

  assign in_raw = {bus.start, bus.inc_b, bus.inc_a};

  // Inputs still high when reset releases are masked until they drop once.
  always_comb begin
    samp_d = in_raw;
    prev_d = samp_q;
    mask_d = mask_q & in_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      samp_q <= '0;
      prev_q <= '0;
      mask_q <= in_raw;
    end else begin
      samp_q <= samp_d;
      prev_q <= prev_d;
      mask_q <= mask_d;
    end
  end

  assign pulse       = samp_q & ~prev_q & ~mask_q;
  assign start_pulse = pulse[NIN-1];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] a_q, a_d;
      logic [3:0] b_q, b_d;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (pulse[gi])
          a_d = (a_q == 4'd9) ? 4'd0 : a_q + 4'd1;
        if (pulse[DIGITS+gi])
          b_d = (b_q == 4'd9) ? 4'd0 : b_q + 4'd1;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= 4'd0;
          b_q <= 4'd0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end

      assign a_vec[4*gi +: 4] = a_q;
      assign b_vec[4*gi +: 4] = b_q;
    end
  endgenerate

`ifdef BCD_ADD_AUTO_EN
  logic pending_q, pending_d;
  logic any_edit;

  assign any_edit = |pulse[2*DIGITS-1:0];
  assign launch   = start_pulse | pending_q;

  // An edit landing on the launch edge is already in the snapshot, so clear wins.
  always_comb begin
    pending_d = pending_q | any_edit;
    if (state_q == S_IDLE && launch)
      pending_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      pending_q <= 1'b0;
    else
      pending_q <= pending_d;
  end
`else
  assign launch = start_pulse;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    wsum_d  = wsum_q;
    sum_d   = sum_q;

    tmp     = {1'b0, wa_q[4*idx_q +: 4]} + {1'b0, wb_q[4*idx_q +: 4]} + {4'd0, carry_q};
    tmp_adj = tmp - 5'd10;
    carry_n = (tmp > 5'd9);
    dig     = carry_n ? tmp_adj[3:0] : tmp[3:0];

    case (state_q)
      S_IDLE: begin
        if (launch)
          state_d = S_LOAD;
      end
      S_LOAD: begin
        wa_d    = a_vec;
        wb_d    = b_vec;
        carry_d = 1'b0;
        idx_d   = '0;
        wsum_d  = '0;
        state_d = S_ADD;
      end
      S_ADD: begin
        wsum_d[4*idx_q +: 4] = dig;
        carry_d              = carry_n;
        if (idx_q == IW'(DIGITS-1)) begin
          sum_d   = {3'b000, carry_n, wsum_d};
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_ADD);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      wa_q    <= '0;
      wb_q    <= '0;
      wsum_q  <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      wa_q    <= wa_d;
      wb_q    <= wb_d;
      wsum_q  <= wsum_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.a_bcd   = a_vec;
  assign bus.b_bcd   = b_vec;
  assign bus.sum_bcd = sum_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
